uart_frame_sender: RTL and testbench
====================================

Name: uart_frame_sender

Overview:
- Sits downstream of the batch collector's dual-port memory and upstream of uart_tx_core, in the iClk_100MHz domain.
- Replaces the bare byte-dump FSM in the top level.
- On each completed batch it reads BATCH_SIZE bytes from memory and sends one framed packet: sync word, length, sequence number, payload, checksum.
- The host can then detect lost or corrupted batches.

Parameters:
- BATCH_SIZE, 1000: payload bytes per frame. Legal range 1..65535.
- SYNC0, 8'hA5: first sync byte.
- SYNC1, 8'h5A: second sync byte.

Ports:
- iClk_100MHz  in  1  system clock.
- iRst  in  1  reset. Synchronous, active-high, clocked by iClk_100MHz.
- iDone  in  1  collector done level. Asynchronous (sample-clock domain).
- oRdEn  out  1  memory read enable.
- oRdAddr  out  32  memory read address.
- iRdData  in  8  memory read data. Valid the cycle after oRdEn.
- oTxStart  out  1  one-cycle start pulse to uart_tx_core.
- oTxData  out  8  byte to transmit.
- iTxBusy  in  1  uart_tx_core busy.
- oBusy  out  1  frame in progress.
- oFrameDone  out  1  one-cycle pulse after the checksum byte completes.
- oSeq  out  8  sequence number of the next frame.

Behaviour:
- Reset values: every output is 0; the sequence counter is 0.
- iDone synchronisation:
  - Passes through a 2-flop synchroniser plus an edge register.
  - A frame is triggered by the rising edge of the synchronised signal only.
  - Trigger latency is 3 cycles from the iDone rise.
  - A rising edge while oBusy=1 is dropped and not queued.
- Frame byte order:
  - SYNC0, SYNC1, LEN[15:8], LEN[7:0], SEQ, payload[0..BATCH_SIZE-1], CHK.
  - LEN = BATCH_SIZE[15:0].
- CHK (default): 8-bit XOR of LEN_hi, LEN_lo, SEQ and all payload bytes. Sync bytes are excluded.
- States:
  - IDLE: on trigger, latch SEQ, clear CHK, clear the byte index, go to LOAD.
  - LOAD:
    - Header or checksum byte: drive oTxData from a mux, go to SEND.
    - Payload byte: assert oRdEn with oRdAddr=index, go to RDWAIT.
  - RDWAIT: capture iRdData into oTxData, go to SEND.
  - SEND: assert oTxStart for 1 cycle, fold oTxData into CHK unless it is a sync or CHK byte, go to GUARD.
  - GUARD: ignore iTxBusy for 1 cycle, since uart_tx_core raises busy one cycle after start. Go to WAIT.
  - WAIT: when iTxBusy=0, increment the index.
    - If the last byte (CHK) was just sent, go to DONE.
    - Otherwise go to LOAD.
  - DONE: pulse oFrameDone, increment the sequence counter, go to IDLE.
- oTxData is held stable from SEND until leaving WAIT.
- oBusy = (state != IDLE).
- The index counts frame positions 0..BATCH_SIZE+5. Payload address = index-5, zero-extended to 32 bits.
- The sequence counter wraps 255 -> 0.
- Reset mid-frame:
  - Takes effect at the next edge: state IDLE, oTxStart=0, sequence counter=0.
  - Any UART byte already started is allowed to finish in uart_tx_core.
  - The partial frame is not resumed.
- iDone held high continuously produces exactly one frame.
- iDone toggling faster than the 3-cycle synchroniser is unsupported.

Optional Feature:
- Macro UART_FRAME_CRC8_EN.
- Defined: CHK is CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR. It covers the same bytes as the XOR checksum, MSB first, and is updated bytewise in SEND (8 unrolled steps, combinational).
- Undefined: CHK is the 8-bit XOR described above.
- The frame format and length are identical in both builds.

Test Plan:
- XOR checksum frame: BATCH_SIZE=4, memory 10 20 30 41, first trigger -> UART bytes A5 5A 00 04 00 10 20 30 41 45. oFrameDone pulses once, then oSeq=1.
- Back-to-back frames: second trigger with the same memory -> SEQ byte 01, CHK 44. After 256 frames oSeq wraps to 00.
- Re-trigger while busy: iDone falls and rises during payload -> no second frame. A rise after oFrameDone -> a new frame starts within 3 cycles.
- Read path: with a bus model, oRdEn pulses once per payload byte, oRdAddr runs 0..3, and each oTxStart sees data read from the previous cycle's address.
- Mid-frame reset: assert iRst during payload byte 2 -> oBusy=0 and oTxStart=0 next cycle, oSeq=0. The next trigger sends a complete fresh frame with SEQ 00.
- CRC8 build (UART_FRAME_CRC8_EN): same stimulus as the XOR checksum frame -> CHK matches the bench CRC-8/0x07 model computed over 00 04 00 10 20 30 41; all other bytes are unchanged.

Source files
------------

// File: rtl/uart_frame_sender.sv
// Framed batch sender: SYNC0 SYNC1 LEN_hi LEN_lo SEQ payload[] CHK over uart_tx_core.
// Define UART_FRAME_CRC8_EN to use CRC-8 (poly 0x07) for CHK instead of the XOR checksum.
module uart_frame_sender #(
    parameter int         BATCH_SIZE = 1000,
    parameter logic [7:0] SYNC0      = 8'hA5,
    parameter logic [7:0] SYNC1      = 8'h5A
) (
    input  logic        iClk_100MHz,
    input  logic        iRst,
    input  logic        iDone,
    output logic        oRdEn,
    output logic [31:0] oRdAddr,
    input  logic [7:0]  iRdData,
    output logic        oTxStart,
    output logic [7:0]  oTxData,
    input  logic        iTxBusy,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic [7:0]  oSeq
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RDWAIT, S_SEND, S_GUARD, S_WAIT, S_DONE
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(BATCH_SIZE + 5);
    localparam logic [15:0] LEN      = 16'(BATCH_SIZE);

    function automatic logic [7:0] chk_next(input logic [7:0] c, input logic [7:0] d);
`ifdef UART_FRAME_CRC8_EN
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
`else
        return c ^ d;
`endif
    endfunction

    state_t      r_state, w_next_state;
    logic [16:0] r_index;
    logic [7:0]  r_tx_data, r_chk, r_seq, r_frame_seq;
    logic        r_done_meta, r_done_sync, r_done_prev;
    logic        w_trigger, w_is_payload, w_fold;
    logic [7:0]  w_hdr_byte;

    assign w_trigger    = r_done_sync & ~r_done_prev;
    assign w_is_payload = (r_index >= 17'd5) && (r_index < LAST_IDX);
    assign w_fold       = (r_index >= 17'd2) && (r_index < LAST_IDX);

    always_comb begin
        case (r_index)
            17'd0:   w_hdr_byte = SYNC0;
            17'd1:   w_hdr_byte = SYNC1;
            17'd2:   w_hdr_byte = LEN[15:8];
            17'd3:   w_hdr_byte = LEN[7:0];
            17'd4:   w_hdr_byte = r_frame_seq;
            default: w_hdr_byte = r_chk;
        endcase
    end

    // NOTE: reset here is synchronous (sampled on the clock edge), matching the rest of this clock domain.
    always_ff @(posedge iClk_100MHz) begin
        if (iRst) begin
            // Synchroniser resets high so an iDone already high at reset is not seen as a new edge.
            r_done_meta <= 1'b1;
            r_done_sync <= 1'b1;
            r_done_prev <= 1'b1;
            r_state     <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_done_meta <= iDone;
            r_done_sync <= r_done_meta;
            r_done_prev <= r_done_sync;
            r_state     <= w_next_state;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        oRdEn        = 1'b0;
        oRdAddr      = '0;
        oTxStart     = 1'b0;
        oFrameDone   = 1'b0;
        oBusy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (w_trigger) w_next_state = S_LOAD;
            S_LOAD: begin
                if (w_is_payload) begin
                    oRdEn        = 1'b1;
                    oRdAddr      = 32'(r_index - 17'd5);
                    w_next_state = S_RDWAIT;
                end else begin
                    w_next_state = S_SEND;
                end
            end
            S_RDWAIT: w_next_state = S_SEND;
            S_SEND: begin
                oTxStart     = 1'b1;
                w_next_state = S_GUARD;
            end
            S_GUARD:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (!iTxBusy)
                    w_next_state = (r_index == LAST_IDX) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                oFrameDone   = 1'b1;
                w_next_state = S_IDLE;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk_100MHz) begin
        if (iRst) begin
            r_index     <= '0;
            r_tx_data   <= '0;
            r_chk       <= '0;
            r_seq       <= '0;
            r_frame_seq <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_trigger) begin
                    r_frame_seq <= r_seq;
                    r_chk       <= '0;
                    r_index     <= '0;
                end
                S_LOAD:   if (!w_is_payload) r_tx_data <= w_hdr_byte;
                S_RDWAIT: r_tx_data <= iRdData;
                S_SEND:   if (w_fold) r_chk <= chk_next(r_chk, r_tx_data);
                S_WAIT:   if (!iTxBusy) r_index <= r_index + 17'd1;
                S_DONE:   r_seq <= r_seq + 8'd1;
                default: ;
            endcase
        end
    end

    assign oTxData = r_tx_data;
    assign oSeq    = r_seq;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Directed bench for uart_frame_sender with BATCH_SIZE=4, a memory model and a UART busy model.
module tb_uart_frame_sender;

    logic        clk = 1'b0;
    logic        rst, done;
    logic        rd_en, tx_start, tx_busy, busy, frame_done;
    logic [31:0] rd_addr;
    logic [7:0]  rd_data, tx_data, seq;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [4];
    logic [7:0]  tx_q[$];
    logic [31:0] addr_q[$];
    int          busy_cnt = 0;
    int          done_cnt = 0;

    always #5 clk = ~clk;

    uart_frame_sender #(.BATCH_SIZE(4)) dut (
        .iClk_100MHz(clk),
        .iRst       (rst),
        .iDone      (done),
        .oRdEn      (rd_en),
        .oRdAddr    (rd_addr),
        .iRdData    (rd_data),
        .oTxStart   (tx_start),
        .oTxData    (tx_data),
        .iTxBusy    (tx_busy),
        .oBusy      (busy),
        .oFrameDone (frame_done),
        .oSeq       (seq)
    );

    // Memory returns data one cycle after the read; UART goes busy after a start for 3 cycles.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr[1:0]];
            addr_q.push_back(rd_addr);
        end
        if (tx_start) begin
            tx_q.push_back(tx_data);
            busy_cnt <= 3;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_chk(input logic [7:0] s);
        logic [7:0] b [7];
        logic [7:0] c;
        b[0] = 8'h00; b[1] = 8'h04; b[2] = s;
        for (int i = 0; i < 4; i++) b[3 + i] = mem[i];
        c = 8'h00;
        for (int i = 0; i < 7; i++) begin
`ifdef UART_FRAME_CRC8_EN
            c = c ^ b[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
`else
            c = c ^ b[i];
`endif
        end
        return c;
    endfunction

    task automatic trigger(input string tag);
        done = 1'b0;
        repeat (4) @(negedge clk);
        done = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " started"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " finished"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] s);
        logic [7:0] e [10];
        e[0] = 8'hA5; e[1] = 8'h5A; e[2] = 8'h00; e[3] = 8'h04; e[4] = s;
        for (int i = 0; i < 4; i++) e[5 + i] = mem[i];
        e[9] = exp_chk(s);
        check({tag, " byte count"}, 32'(tx_q.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            if (base + i < tx_q.size())
                check($sformatf("%s byte%0d", tag, i), 32'(tx_q[base + i]), 32'(e[i]));
    endtask

    initial begin
        int base, abase, d0, n;
        mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h41;
        rst  = 1'b1;
        done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy",  32'(busy),       32'd0);
        check("rst start", 32'(tx_start),   32'd0);
        check("rst fdone", 32'(frame_done), 32'd0);
        check("rst rden",  32'(rd_en),      32'd0);
        check("rst addr",  rd_addr,         32'd0);
        check("rst data",  32'(tx_data),    32'd0);
        check("rst seq",   32'(seq),        32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: exact trigger latency, byte stream, read addresses
        base = tx_q.size(); abase = addr_q.size(); d0 = done_cnt;
        done = 1'b1;
        repeat (2) @(negedge clk);
        check("f1 not yet busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("f1 busy at 3", 32'(busy), 32'd1);
        wait_frame("f1");
        check_frame("f1", base, 8'h00);
        check("f1 chk xor", 32'(exp_chk(8'h00)),
`ifdef UART_FRAME_CRC8_EN
              32'(exp_chk(8'h00)));
`else
              32'h45);
`endif
        check("f1 done pulses", 32'(done_cnt - d0), 32'd1);
        check("f1 seq", 32'(seq), 32'd1);
        check("f1 reads", 32'(addr_q.size() - abase), 32'd4);
        for (int i = 0; i < 4; i++)
            if (abase + i < addr_q.size())
                check($sformatf("f1 addr%0d", i), addr_q[abase + i], 32'(i));

        // Frame 2: iDone re-toggled mid-payload must not queue another frame
        base = tx_q.size(); abase = addr_q.size(); d0 = done_cnt;
        trigger("f2");
        n = 0;
        while (addr_q.size() < abase + 2 && n < 500) begin @(negedge clk); n++; end
        check("f2 reached payload", 32'(n < 500), 32'd1);
        done = 1'b0;
        repeat (5) @(negedge clk);
        done = 1'b1;
        wait_frame("f2");
        check_frame("f2", base, 8'h01);
        repeat (20) @(negedge clk);
        check("f2 no requeue busy", 32'(busy), 32'd0);
        check("f2 done pulses", 32'(done_cnt - d0), 32'd1);
        check("f2 seq", 32'(seq), 32'd2);

        // Frame 3: a rise after frame done starts promptly
        base = tx_q.size();
        trigger("f3");
        wait_frame("f3");
        check_frame("f3", base, 8'h02);

        // Frame 4: reset during payload byte 2
        base = tx_q.size();
        trigger("f4");
        n = 0;
        while (tx_q.size() < base + 8 && n < 500) begin @(negedge clk); n++; end
        check("f4 reached payload2", 32'(n < 500), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst busy",  32'(busy),     32'd0);
        check("mid rst start", 32'(tx_start), 32'd0);
        check("mid rst seq",   32'(seq),      32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mid rst no resume", 32'(tx_q.size() - base), 32'd8);
        check("mid rst idle", 32'(busy), 32'd0);

        // Fresh frame after reset carries SEQ 00
        base = tx_q.size();
        trigger("fresh");
        wait_frame("fresh");
        check_frame("fresh", base, 8'h00);
        check("fresh seq", 32'(seq), 32'd1);

        // Sequence wrap 255 -> 0
        for (int k = 0; k < 254; k++) begin
            trigger($sformatf("wrap%0d", k));
            wait_frame($sformatf("wrap%0d", k));
        end
        check("seq at 255", 32'(seq), 32'd255);
        base = tx_q.size();
        trigger("last");
        wait_frame("last");
        check_frame("last", base, 8'hFF);
        check("seq wrapped", 32'(seq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
